// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - single-outstanding SRAM-style request to AXI4 single-beat bridge
module sram_axi_bridge #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    // SRAM-style upstream port
    input  logic              sram_en,
    input  logic [3:0]        sram_we,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_wdata,
    output logic              sram_addr_ok,
    output logic              sram_data_ok,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              sram_err,
    // AXI read address channel
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    // AXI read data channel
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address channel
    output logic [3:0]        awid,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    // AXI write data channel
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // AXI write response channel
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_AW,
        S_WR_B,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                aw_fire;
    logic                w_fire;

    // Single-beat, INCR, 4-byte transfers only
    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

    // Request fields come straight from the latched registers so they stay stable under valid
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign sram_rdata = rdata_q;
    assign sram_err   = err_q;

    // State and request/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state and handshake outputs; the write phase tracks AW and W completion separately
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        aw_fire      = 1'b0;
        w_fire       = 1'b0;
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                sram_addr_ok = 1'b1;
                if (sram_en) begin
                    addr_d    = sram_addr;
                    wdata_d   = sram_wdata;
                    wstrb_d   = sram_we;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (sram_we == 4'd0) ? S_RD_A : S_WR_AW;
                end
            end
            S_RD_A: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = (rresp != 2'b00);
                    state_d = S_RESP;
                end
            end
            S_WR_AW: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_fire   = awvalid && awready;
                w_fire    = wvalid && wready;
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_B;
                end
            end
            S_WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                sram_data_ok = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
